// File: rtl/sprite_plotter_pkg.sv
// Shared sprite geometry, colours, FSM encoding and the position-to-column
// mapping used by both the plotter and the game FSM's hit detection.
package sprite_plotter_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int POS_W = 3;
  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int COL_W = 3;

  localparam int X_BASE_DEF  = 16;
  localparam int X_STEP_DEF  = 36;
  localparam int PRESS_Y_DEF = 20;
  localparam int PRESS_W_DEF = 16;
  localparam int PRESS_H_DEF = 16;
  localparam int GARB_Y_DEF  = 80;
  localparam int GARB_W_DEF  = 8;
  localparam int GARB_H_DEF  = 8;

  localparam logic [COL_W-1:0] PRESS_COL_DEF = 3'b111;
  localparam logic [COL_W-1:0] GARB_COL_DEF  = 3'b010;
  localparam logic [COL_W-1:0] BLACK         = 3'b000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Positions 4 and 5 fold back onto columns 2 and 1.
  function automatic logic [POS_W-1:0] col_of(input logic [POS_W-1:0] p);
    return (p <= 3'd3) ? p : (3'd6 - p);
  endfunction

  function automatic logic position_ok(input logic item, input logic [POS_W-1:0] p);
    return item ? (p <= 3'd5) : (p <= 3'd3);
  endfunction

endpackage

// File: rtl/sprite_plotter_raster_counter.sv
// Row-major dx/dy raster counter for a W x H sprite; dx runs fastest and the
// counter wraps to (0,0) after the last pixel.
module raster_counter #(
  parameter int W = 16,
  parameter int H = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       enable,
  output logic [7:0] dx,
  output logic [6:0] dy,
  output logic       row_end,
  output logic       last
);

  localparam logic [7:0] DX_MAX = 8'(W - 1);
  localparam logic [6:0] DY_MAX = 7'(H - 1);

  assign row_end = (dx == DX_MAX);
  assign last    = row_end && (dy == DY_MAX);

  // Pixel index advance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dx <= 8'd0;
      dy <= 7'd0;
    end else if (clear) begin
      dx <= 8'd0;
      dy <= 7'd0;
    end else if (enable) begin
      if (row_end) begin
        dx <= 8'd0;
        dy <= (dy == DY_MAX) ? 7'd0 : (dy + 7'd1);
      end else begin
        dx <= dx + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: accepts one draw/erase request per handshake and streams
// one pixel write per clock to the VGA adapter, then pulses done.
module sprite_plotter
  import sprite_plotter_pkg::*;
#(
  parameter int               X_BASE    = X_BASE_DEF,
  parameter int               X_STEP    = X_STEP_DEF,
  parameter int               PRESS_Y   = PRESS_Y_DEF,
  parameter int               PRESS_W   = PRESS_W_DEF,
  parameter int               PRESS_H   = PRESS_H_DEF,
  parameter int               GARB_Y    = GARB_Y_DEF,
  parameter int               GARB_W    = GARB_W_DEF,
  parameter int               GARB_H    = GARB_H_DEF,
  parameter logic [COL_W-1:0] PRESS_COL = PRESS_COL_DEF,
  parameter logic [COL_W-1:0] GARB_COL  = GARB_COL_DEF
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_item,
  input  logic             req_erase,
  input  logic [POS_W-1:0] req_position,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             done,
  output logic             err
);

  // Rightmost column (3) must still fit both sprites on screen.
  if ((X_BASE + 3 * X_STEP + PRESS_W > SCREEN_W) ||
      (X_BASE + 3 * X_STEP + (PRESS_W - GARB_W) / 2 + GARB_W > SCREEN_W) ||
      (PRESS_Y + PRESS_H > SCREEN_H) || (GARB_Y + GARB_H > SCREEN_H)) begin : g_geometry_bad
    $error("sprite_plotter: sprite geometry exceeds the 160x120 screen");
  end

  localparam logic [X_W-1:0] XB   = 8'(X_BASE);
  localparam logic [X_W-1:0] XS   = 8'(X_STEP);
  localparam logic [X_W-1:0] GOFF = 8'((PRESS_W - GARB_W) / 2);
  localparam logic [Y_W-1:0] PY   = 7'(PRESS_Y);
  localparam logic [Y_W-1:0] GY   = 7'(GARB_Y);

  state_t             state;
  logic               item_r;
  logic [X_W-1:0]     ox_r;
  logic [Y_W-1:0]     oy_r;

  logic               accept_s;
  logic [POS_W-1:0]   col_s;
  logic               pos_ok_s;
  logic [X_W-1:0]     ox_s;
  logic [Y_W-1:0]     oy_s;
  logic [COL_W-1:0]   colour_s;

  logic [7:0]         p_dx, g_dx, dx_s;
  logic [6:0]         p_dy, g_dy, dy_s;
  logic               p_row_end, g_row_end, row_end_s;
  logic               p_last, g_last, last_s;

  assign accept_s = req_valid && req_ready;

  raster_counter #(.W(PRESS_W), .H(PRESS_H)) u_press_cnt (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .clear   (accept_s),
    .enable  ((state == S_DRAW) && item_r),
    .dx      (p_dx),
    .dy      (p_dy),
    .row_end (p_row_end),
    .last    (p_last)
  );

  raster_counter #(.W(GARB_W), .H(GARB_H)) u_garb_cnt (
    .clk     (CLOCK_50),
    .reset_n (reset_n),
    .clear   (accept_s),
    .enable  ((state == S_DRAW) && !item_r),
    .dx      (g_dx),
    .dy      (g_dy),
    .row_end (g_row_end),
    .last    (g_last)
  );

  // Request decode: origin and colour for the sprite being offered
  always_comb begin
    col_s    = col_of(req_position);
    pos_ok_s = position_ok(req_item, req_position);
    if (req_item) begin
      ox_s     = XB + XS * {5'd0, col_s};
      oy_s     = PY;
      colour_s = req_erase ? BLACK : PRESS_COL;
    end else begin
      ox_s     = XB + XS * {5'd0, col_s} + GOFF;
      oy_s     = GY;
      colour_s = req_erase ? BLACK : GARB_COL;
    end
  end

  // Select the counter belonging to the latched sprite
  always_comb begin
    if (item_r) begin
      dx_s = p_dx; dy_s = p_dy; row_end_s = p_row_end; last_s = p_last;
    end else begin
      dx_s = g_dx; dy_s = g_dy; row_end_s = g_row_end; last_s = g_last;
    end
  end

  // Control FSM with registered pixel outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      plot      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      x         <= 8'd0;
      y         <= 7'd0;
      colour    <= 3'd0;
      item_r    <= 1'b0;
      ox_r      <= 8'd0;
      oy_r      <= 7'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept_s) begin
            req_ready <= 1'b0;
            item_r    <= req_item;
            if (pos_ok_s) begin
              state  <= S_DRAW;
              plot   <= 1'b1;
              x      <= ox_s;
              y      <= oy_s;
              colour <= colour_s;
              ox_r   <= ox_s;
              oy_r   <= oy_s;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (last_s) begin
            state <= S_DONE;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else if (row_end_s) begin
            x <= ox_r;
            y <= oy_r + dy_s + 7'd1;
          end else begin
            x <= ox_r + dx_s + 8'd1;
            y <= oy_r + dy_s;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          err       <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          plot      <= 1'b0;
          done      <= 1'b0;
          err       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench: a pixel-list model predicts every cycle's outputs,
// with directed literal checks for the key sprites plus randomized requests.
module tb_sprite_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_item;
  logic       req_erase;
  logic [2:0] req_position;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;
  logic       err;

  sprite_plotter dut (
    .CLOCK_50     (CLOCK_50),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_item     (req_item),
    .req_erase    (req_erase),
    .req_position (req_position),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .done         (done),
    .err          (err)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Model: one queue entry per future output cycle of the current request.
  typedef struct packed {
    logic       plot;
    logic       done;
    logic       err;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } ent_t;

  ent_t       exp_q[$];
  logic [7:0] hold_x;
  logic [6:0] hold_y;
  logic [2:0] hold_c;
  int         acc_count = 0;

  function automatic void enqueue(input logic item, input logic erase, input int p);
    int col, ox, oy, w, h;
    logic [2:0] c;
    ent_t e;
    e = '0;
    if ((item && p > 5) || (!item && p > 3)) begin
      e.done = 1'b1;
      e.err  = 1'b1;
      exp_q.push_back(e);
      return;
    end
    col = (p <= 3) ? p : 6 - p;
    w   = item ? 16 : 8;
    h   = item ? 16 : 8;
    ox  = 16 + col * 36 + (item ? 0 : 4);
    oy  = item ? 20 : 80;
    c   = erase ? 3'd0 : (item ? 3'd7 : 3'd2);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        e.plot = 1'b1;
        e.done = 1'b0;
        e.err  = 1'b0;
        e.x    = 8'(ox + xx);
        e.y    = 7'(oy + yy);
        e.c    = c;
        exp_q.push_back(e);
      end
    end
    e = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Model clock edge: retire one cycle, accept when idle
  initial begin
    ent_t e;
    bit   was_idle;
    hold_x = 8'd0;
    hold_y = 7'd0;
    hold_c = 3'd0;
    forever begin
      @(posedge CLOCK_50);
      if (!reset_n) begin
        exp_q.delete();
        hold_x = 8'd0;
        hold_y = 7'd0;
        hold_c = 3'd0;
      end else begin
        was_idle = (exp_q.size() == 0);
        if (!was_idle) begin
          e = exp_q.pop_front();
          if (e.plot) begin
            hold_x = e.x;
            hold_y = e.y;
            hold_c = e.c;
          end
        end
        if (was_idle && req_valid) begin
          acc_count++;
          enqueue(req_item, req_erase, int'(req_position));
        end
      end
    end
  end

  // Per-cycle compare of every output against the model
  initial begin
    ent_t        e;
    logic [21:0] exp_v;
    logic [21:0] act_v;
    logic        rdy;
    forever begin
      @(negedge CLOCK_50);
      e   = (exp_q.size() > 0) ? exp_q[0] : '0;
      rdy = (exp_q.size() == 0);
      exp_v = {rdy, e.plot, e.done, e.err,
               e.plot ? e.x : hold_x, e.plot ? e.y : hold_y, e.plot ? e.c : hold_c};
      act_v = {req_ready, plot, done, err, x, y, colour};
      check("cycle", 32'(act_v), 32'(exp_v));
    end
  end

  // Wait (bounded) for the model to see the pending request accepted, then drop valid
  task automatic wait_accept(input string name);
    int start;
    start = acc_count;
    for (int k = 0; k < 600; k++) begin
      @(posedge CLOCK_50);
      #1;
      if (acc_count != start) break;
    end
    check({name, "_accept"}, 32'(acc_count - start), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic send(input logic item, input logic erase, input logic [2:0] pos, input string name);
    req_item     = item;
    req_erase    = erase;
    req_position = pos;
    req_valid    = 1'b1;
    wait_accept(name);
  endtask

  // Literal checks on one request, starting right after its accept edge
  task automatic observe(input string name, input int fx, input int fy, input int lx, input int ly,
                         input int col, input int n, input logic e);
    int         cnt;
    int         done_cyc;
    logic       seen_err;
    logic [7:0] last_x;
    logic [6:0] last_y;
    cnt = 0; done_cyc = -1; seen_err = 1'b0; last_x = 8'd0; last_y = 7'd0;
    for (int c = 1; (c <= n + 3) && (done_cyc < 0); c++) begin
      @(negedge CLOCK_50);
      if (plot) begin
        if (cnt == 0) begin
          check({name, "_first_x"}, 32'(x), 32'(fx));
          check({name, "_first_y"}, 32'(y), 32'(fy));
          check({name, "_colour"}, 32'(colour), 32'(col));
        end
        cnt++;
        last_x = x;
        last_y = y;
      end
      if (done) begin
        done_cyc = c;
        seen_err = err;
      end
    end
    check({name, "_plots"}, 32'(cnt), 32'(n));
    check({name, "_done_lat"}, 32'(done_cyc), 32'(n + 1));
    check({name, "_err"}, 32'(seen_err), 32'(e));
    if (n > 0) begin
      check({name, "_last_x"}, 32'(last_x), 32'(lx));
      check({name, "_last_y"}, 32'(last_y), 32'(ly));
    end
  endtask

  initial begin
    int cnt;
    reset_n      = 1'b0;
    req_valid    = 1'b1;
    req_item     = 1'b1;
    req_erase    = 1'b0;
    req_position = 3'd0;

    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_xyc", 32'({x, y, colour}), 32'd0);
    reset_n = 1'b1;

    wait_accept("press0");
    observe("press0", 16, 20, 31, 35, 7, 256, 1'b0);

    send(1'b1, 1'b0, 3'd5, "press5");
    observe("press5", 52, 20, 67, 35, 7, 256, 1'b0);
    send(1'b1, 1'b0, 3'd1, "press1");
    observe("press1", 52, 20, 67, 35, 7, 256, 1'b0);

    send(1'b0, 1'b1, 3'd3, "gerase3");
    observe("gerase3", 128, 80, 135, 87, 0, 64, 1'b0);

    send(1'b0, 1'b0, 3'd4, "ginv4");
    observe("ginv4", 0, 0, 0, 0, 0, 0, 1'b1);

    // Reset mid-draw with a held request pending
    send(1'b1, 1'b0, 3'd2, "press2");
    req_item     = 1'b0;
    req_erase    = 1'b0;
    req_position = 3'd1;
    req_valid    = 1'b1;
    cnt = 0;
    for (int c = 0; (c < 20) && (cnt < 10); c++) begin
      @(negedge CLOCK_50);
      if (plot) cnt++;
    end
    check("mid_plots", 32'(cnt), 32'd10);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    check("mid_rst_plot", 32'(plot), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    wait_accept("held");
    observe("held", 56, 80, 63, 87, 2, 64, 1'b0);

    for (int i = 0; i < 30; i++) begin
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), "rand");
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
    end

    for (int k = 0; (k < 400) && (exp_q.size() != 0); k++) @(negedge CLOCK_50);
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge CLOCK_50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
- Pixel-write engine on the far side of the game FSM's draw-request interface (item / erase / position).
- Takes one sprite request per handshake: either the press or the garbage, drawn or erased, at a logical position.
- Rasterises the request into one pixel write per clock on the VGA adapter's x / y / colour / plot inputs.
- Signals completion, so requesters wait on done instead of hard-coded delay counts.

Parameters:
- X_BASE, 16: x of column 0 left edge.
- X_STEP, 36: x pitch between columns.
- PRESS_Y, 20: press sprite top y.
- PRESS_W, 16: press sprite width.
- PRESS_H, 16: press sprite height.
- GARB_Y, 80: garbage sprite top y.
- GARB_W, 8: garbage sprite width.
- GARB_H, 8: garbage sprite height.
- PRESS_COL, 3'b111: press colour.
- GARB_COL, 3'b010: garbage colour.

Ports:
- CLOCK_50, in, 1: sole clock.
- reset_n, in, 1: reset, synchronous, active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- req_item, in, 1: 1 = press sprite, 0 = garbage sprite.
- req_erase, in, 1: 1 = erase (black), 0 = draw.
- req_position, in, 3: logical position.
- x, out, 8: pixel x.
- y, out, 7: pixel y.
- colour, out, 3: pixel colour.
- plot, out, 1: pixel write strobe.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: one-cycle pulse for an out-of-range position.

Behaviour:
- Reset: applied at a clock edge while reset_n=0.
  - State goes to IDLE; raster counters go to 0.
  - Outputs: plot=0, done=0, err=0, x=0, y=0, colour=0, req_ready=1 from the first cycle after reset.
  - Reset mid-draw aborts the draw: plot=0 next cycle, no done pulse.
- Handshake: a request is accepted on a clock edge where req_valid && req_ready. All request fields are latched at that edge.
  - The requester holds valid and fields until accepted.
  - req_valid is ignored while req_ready=0.
- Position to column mapping: col = (p <= 3) ? p : 6 - p.
  - Press accepts p = 0..5, so p=4 maps to col 2 and p=5 maps to col 1.
  - Garbage accepts p = 0..3, col = p.
- Sprite origin:
  - Press: ox = X_BASE + col*X_STEP, oy = PRESS_Y.
  - Garbage: ox = X_BASE + col*X_STEP + (PRESS_W - GARB_W)/2, oy = GARB_Y.
  - Origin is computed at accept time in 8-bit arithmetic.
  - Parameters must satisfy ox + W <= 160 and oy + H <= 120. An elaboration-time check fails otherwise.
- Colour: erase gives 3'b000; otherwise PRESS_COL or GARB_COL.
- FSM:
  - IDLE: req_ready=1. On accept with valid position, go to DRAW with dx=dy=0. On accept with invalid position (press p>=6, garbage p>=4), go to DONE and pulse err in the DONE cycle; zero plots.
  - DRAW: req_ready=0, plot=1, x = ox+dx, y = oy+dy. dx increments each cycle (x fastest); at dx=W-1, dx wraps to 0 and dy increments. After the pixel with dx=W-1 and dy=H-1, go to DONE.
  - DONE: done=1 for exactly one cycle, req_ready=0, plot=0. Then go to IDLE.
- Latency: accept at edge N gives the first plot in cycle N+1 and the last plot in cycle N+W*H. done is in cycle N+W*H+1, and the next accept is possible at edge N+W*H+2.
  - Press: 256 plots. Garbage: 64 plots.
- plot is high exactly W*H consecutive cycles per valid request. x, y and colour are don't-care when plot=0 but must hold their last values.
- A request presented during DONE is not accepted until IDLE.

Decomposition:
- Shared package: sprite geometry constants, colour constants, position widths, FSM state encoding (IDLE / DRAW / DONE), and the column-mapping function. The game FSM uses the same mapping for hit detection.
- Sub-module raster_counter: W/H-parameterised dx/dy counter with clear, enable, and a last-pixel flag.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with req_valid=1 -> plot=0, done=0, err=0, req_ready=1 the cycle after release; no accept while reset_n=0.
- Press draw, item=1, erase=0, pos=0, accepted at edge N -> first plot (16,20,7) at N+1; last plot (31,35) at N+256; done at N+257; 256 plots total.
- Press draw, pos=5 -> first pixel (52,20), identical to the pos=1 pixel sequence.
- Garbage erase, item=0, erase=1, pos=3 -> 64 plots from (128,80) to (135,87), colour 0; done after the 64th plot.
- Invalid request, item=0, pos=4 -> zero plots; err=1 and done=1 in the same cycle, one cycle after accept.
- Hold req_valid=1 during a press draw, then assert reset_n=0 after plot 10 -> no accept while busy; plot=0 the cycle after the reset edge; no done; req_ready=1 after release; the held request is accepted on the next edge.
